spi_midi_cmd_decoder: RTL and testbench

//  Parametrised next-generation MIDI-over-SPI command decoder. Consumes bytes already

---
 rtl/spi_midi_pkg.sv | 47 ++++
 rtl/cmd_event_fifo.sv | 57 +++++
 rtl/spi_midi_cmd_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_spi_midi_cmd_decoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_midi_pkg.sv
// Shared definitions for the MIDI-over-SPI command decoder: status nibbles,
// packed event layout and parser state encodings.
package spi_midi_pkg;

    localparam logic [3:0] NIB_NOTEOFF = 4'h8;
    localparam logic [3:0] NIB_NOTEON  = 4'h9;

    localparam int CH_W   = 4;
    localparam int DATA_W = 7;

    // Voice is carried at full data-byte width; the top trims it to VOICE_W.
    typedef struct packed {
        logic              note_on;
        logic [CH_W-1:0]   channel;
        logic [DATA_W-1:0] voice;
        logic [DATA_W-1:0] note;
        logic [DATA_W-1:0] velocity;
    } midi_evt_t;

    localparam int EVT_W = $bits(midi_evt_t);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_VOICE = 2'd1;
    localparam logic [1:0] ST_NOTE  = 2'd2;
    localparam logic [1:0] ST_VEL   = 2'd3;

    function automatic logic is_note_status(input logic [7:0] b);
        return (b[7:4] == NIB_NOTEON) || (b[7:4] == NIB_NOTEOFF);
    endfunction

    // A note-on with zero velocity is reported as a plain note-off.
    function automatic midi_evt_t make_evt(input logic on, input logic [CH_W-1:0] ch,
                                           input logic [DATA_W-1:0] voice,
                                           input logic [DATA_W-1:0] note,
                                           input logic [DATA_W-1:0] vel);
        midi_evt_t e;
        logic      on_eff;
        on_eff     = on && (vel != '0);
        e.note_on  = on_eff;
        e.channel  = ch;
        e.voice    = voice;
        e.note     = on_eff ? note : '0;
        e.velocity = on_eff ? vel : '0;
        return e;
    endfunction

endpackage

// File: rtl/cmd_event_fifo.sv
// Synchronous event FIFO with registered storage; head reads as zero when empty.
module cmd_event_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W:0]   cnt_q;
    logic             pop_ok;
    logic             push_ok;

    assign o_empty    = (cnt_q == '0);
    assign o_full     = (cnt_q == (PTR_W + 1)'(DEPTH));
    assign pop_ok     = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign push_ok    = i_push && (!o_full || pop_ok);
    assign o_overflow = i_push && !push_ok;
    assign o_level    = cnt_q;
    assign o_data     = o_empty ? '0 : mem[rd_q];

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_midi_cmd_decoder.sv
// NOTEON/NOTEOFF frame parser feeding an event FIFO.
// Optional running status is enabled by defining MIDI_RUNNING_STATUS_EN.
//
// state    | meaning
// ST_IDLE  | waiting for a 8n/9n status byte
// ST_VOICE | status seen, expecting voice byte
// ST_NOTE  | note-on, expecting note byte
// ST_VEL   | note-on, expecting velocity byte
module spi_midi_cmd_decoder
    import spi_midi_pkg::*;
#(
    parameter int NUM_VOICES     = 16,
    parameter int VOICE_W        = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_byte_valid,
    input  logic [7:0]                    i_byte,
    output logic                          o_evt_valid,
    input  logic                          i_evt_ready,
    output logic                          o_evt_note_on,
    output logic [3:0]                    o_evt_channel,
    output logic [VOICE_W-1:0]            o_evt_voice,
    output logic [6:0]                    o_evt_note,
    output logic [6:0]                    o_evt_velocity,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [7:0]                    o_err_count,
    output logic                          o_busy
);
`ifdef MIDI_RUNNING_STATUS_EN
    localparam bit RUN_EN = 1'b1;
`else
    localparam bit RUN_EN = 1'b0;
`endif
    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [1:0]        state_q, state_d;
    logic              is_on_q, is_on_d;
    logic [CH_W-1:0]   channel_q, channel_d;
    logic [DATA_W-1:0] voice_q, voice_d;
    logic [DATA_W-1:0] note_q, note_d;
    logic              bad_q, bad_d;
    logic              run_valid_q, run_valid_d;
    logic              run_on_q, run_on_d;
    logic [CH_W-1:0]   run_ch_q, run_ch_d;
    logic [TMO_W-1:0]  tmo_q;
    logic              tmo_hit;
    logic              err_fsm;
    logic              take_voice;
    logic              voice_on;
    logic [CH_W-1:0]   voice_ch;
    logic              voice_bad;
    logic              emit;
    midi_evt_t         emit_evt;
    logic              push_q;
    midi_evt_t         push_evt_q;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_overflow;
    logic [EVT_W-1:0]  fifo_data;
    midi_evt_t         head;
    logic [7:0]        err_q;
    logic              unused_voice_bits;

    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (state_q != ST_IDLE) && !i_byte_valid
                       && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign voice_bad = (32'(i_byte[6:0]) >= NUM_VOICES);

    always_comb begin
        state_d     = state_q;
        is_on_d     = is_on_q;
        channel_d   = channel_q;
        voice_d     = voice_q;
        note_d      = note_q;
        bad_d       = bad_q;
        run_valid_d = run_valid_q;
        run_on_d    = run_on_q;
        run_ch_d    = run_ch_q;
        err_fsm     = 1'b0;
        take_voice  = 1'b0;
        voice_on    = is_on_q;
        voice_ch    = channel_q;
        emit        = 1'b0;
        emit_evt    = '0;
        if (tmo_hit) begin
            state_d     = ST_IDLE;
            err_fsm     = 1'b1;
            run_valid_d = 1'b0;
        end else if (i_byte_valid) begin
            if (i_byte[7]) begin
                // Status mid-frame aborts the frame but is itself parsed this cycle.
                err_fsm = (state_q != ST_IDLE);
                if (is_note_status(i_byte)) begin
                    state_d     = ST_VOICE;
                    is_on_d     = (i_byte[7:4] == NIB_NOTEON);
                    channel_d   = i_byte[3:0];
                    bad_d       = 1'b0;
                    run_valid_d = 1'b1;
                    run_on_d    = (i_byte[7:4] == NIB_NOTEON);
                    run_ch_d    = i_byte[3:0];
                end else begin
                    state_d     = ST_IDLE;
                    run_valid_d = 1'b0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        take_voice = RUN_EN && run_valid_q;
                        voice_on   = run_on_q;
                        voice_ch   = run_ch_q;
                    end
                    ST_VOICE: take_voice = 1'b1;
                    ST_NOTE: begin
                        note_d  = i_byte[6:0];
                        state_d = ST_VEL;
                    end
                    default: begin
                        state_d  = ST_IDLE;
                        emit     = !bad_q;
                        emit_evt = make_evt(is_on_q, channel_q, voice_q, note_q, i_byte[6:0]);
                    end
                endcase
                if (take_voice) begin
                    voice_d   = i_byte[6:0];
                    is_on_d   = voice_on;
                    channel_d = voice_ch;
                    note_d    = '0;
                    bad_d     = voice_bad;
                    err_fsm   = voice_bad;
                    if (voice_on) begin
                        state_d = ST_NOTE;
                    end else begin
                        state_d  = ST_IDLE;
                        emit     = !voice_bad;
                        emit_evt = make_evt(1'b0, voice_ch, i_byte[6:0], '0, '0);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            is_on_q     <= 1'b0;
            channel_q   <= '0;
            voice_q     <= '0;
            note_q      <= '0;
            bad_q       <= 1'b0;
            run_valid_q <= 1'b0;
            run_on_q    <= 1'b0;
            run_ch_q    <= '0;
            push_q      <= 1'b0;
            push_evt_q  <= '0;
        end else begin
            state_q     <= state_d;
            is_on_q     <= is_on_d;
            channel_q   <= channel_d;
            voice_q     <= voice_d;
            note_q      <= note_d;
            bad_q       <= bad_d;
            run_valid_q <= run_valid_d;
            run_on_q    <= run_on_d;
            run_ch_q    <= run_ch_d;
            push_q      <= emit;
            push_evt_q  <= emit_evt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || (state_q == ST_IDLE) || i_byte_valid || tmo_hit || (TIMEOUT_CYCLES == 0)) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_q <= '0;
        end else if ((err_fsm || fifo_overflow) && (err_q != 8'hFF)) begin
            err_q <= err_q + 1'b1;
        end
    end

    cmd_event_fifo #(
        .W     (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (push_q),
        .i_data     (push_evt_q),
        .i_pop      (i_evt_ready),
        .o_data     (fifo_data),
        .o_empty    (fifo_empty),
        .o_full     (fifo_full),
        .o_overflow (fifo_overflow),
        .o_level    (o_fifo_level)
    );

    assign head              = midi_evt_t'(fifo_data);
    assign o_evt_valid       = !fifo_empty;
    assign o_evt_note_on     = head.note_on;
    assign o_evt_channel     = head.channel;
    assign o_evt_voice       = head.voice[VOICE_W-1:0];
    assign o_evt_note        = head.note;
    assign o_evt_velocity    = head.velocity;
    assign o_err_count       = err_q;
    assign o_busy            = (state_q != ST_IDLE);
    assign unused_voice_bits = ^head.voice ^ fifo_full;

endmodule

// File: tb/tb_spi_midi_cmd_decoder.sv
// Directed bench for spi_midi_cmd_decoder: frame table plus FIFO, timeout,
// running-status, reset and saturation sequences.
module tb_spi_midi_cmd_decoder;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       byte_valid;
    logic [7:0] byte_v;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_note_on;
    logic [3:0] evt_channel;
    logic [3:0] evt_voice;
    logic [6:0] evt_note;
    logic [6:0] evt_velocity;
    logic [2:0] fifo_level;
    logic [7:0] err_count;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_err  = 0;

    always #5 clk = ~clk;

    spi_midi_cmd_decoder #(
        .NUM_VOICES     (16),
        .VOICE_W        (4),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_byte_valid   (byte_valid),
        .i_byte         (byte_v),
        .o_evt_valid    (evt_valid),
        .i_evt_ready    (evt_ready),
        .o_evt_note_on  (evt_note_on),
        .o_evt_channel  (evt_channel),
        .o_evt_voice    (evt_voice),
        .o_evt_note     (evt_note),
        .o_evt_velocity (evt_velocity),
        .o_fifo_level   (fifo_level),
        .o_err_count    (err_count),
        .o_busy         (busy)
    );

    typedef struct {
        int              nb;
        logic [0:5][7:0] b;
        bit              has_evt;
        logic            on;
        logic [3:0]      ch;
        logic [3:0]      voice;
        logic [6:0]      note;
        logic [6:0]      vel;
        int              err_inc;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_v     = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
    endtask

    // Called right after the final byte's strobe edge: head must appear one edge later.
    task automatic expect_event(input string tag, input logic on, input logic [3:0] ch,
                                input logic [3:0] voice, input logic [6:0] note, input logic [6:0] vel);
        check({tag, ".early"}, 32'(evt_valid), 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(evt_valid), 32'd1);
        check({tag, ".on"},    32'(evt_note_on), 32'(on));
        check({tag, ".ch"},    32'(evt_channel), 32'(ch));
        check({tag, ".voice"}, 32'(evt_voice), 32'(voice));
        check({tag, ".note"},  32'(evt_note), 32'(note));
        check({tag, ".vel"},   32'(evt_velocity), 32'(vel));
        pop_one();
        check({tag, ".popped"}, 32'(evt_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{4, {8'h91, 8'h05, 8'h3C, 8'h64, 8'h00, 8'h00}, 1'b1, 1'b1, 4'd1,  4'd5,  7'd60,  7'd100, 0};
        vecs[1] = '{2, {8'h80, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 4'd0,  4'd3,  7'd0,   7'd0,   0};
        vecs[2] = '{4, {8'h90, 8'h02, 8'h40, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 4'd0,  4'd2,  7'd0,   7'd0,   0};
        vecs[3] = '{6, {8'h90, 8'h07, 8'h90, 8'h01, 8'h30, 8'h50}, 1'b1, 1'b1, 4'd0,  4'd1,  7'd48,  7'd80,  1};
        vecs[4] = '{4, {8'h90, 8'h14, 8'h3C, 8'h64, 8'h00, 8'h00}, 1'b0, 1'b0, 4'd0,  4'd0,  7'd0,   7'd0,   1};
        vecs[5] = '{4, {8'h90, 8'h00, 8'h3C, 8'h64, 8'h00, 8'h00}, 1'b1, 1'b1, 4'd0,  4'd0,  7'd60,  7'd100, 0};
        vecs[6] = '{4, {8'h9F, 8'h0F, 8'h7F, 8'h7F, 8'h00, 8'h00}, 1'b1, 1'b1, 4'd15, 4'd15, 7'd127, 7'd127, 0};
        vecs[7] = '{4, {8'h90, 8'h10, 8'h3C, 8'h64, 8'h00, 8'h00}, 1'b0, 1'b0, 4'd0,  4'd0,  7'd0,   7'd0,   1};
        vecs[8] = '{3, {8'hF8, 8'h8A, 8'h09, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 4'd10, 4'd9,  7'd0,   7'd0,   0};
        vecs[9] = '{2, {8'h80, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 4'd0,  4'd0,  7'd0,   7'd0,   1};

        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_v     = 8'h00;
        evt_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", 32'(evt_valid), 32'd0);
        check("rst.busy",  32'(busy), 32'd0);
        check("rst.level", 32'(fifo_level), 32'd0);
        check("rst.err",   32'(err_count), 32'd0);
        check("rst.note",  32'(evt_note), 32'd0);
        check("rst.vel",   32'(evt_velocity), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < vecs[i].nb; j++) send(vecs[i].b[j]);
            if (vecs[i].has_evt) begin
                expect_event($sformatf("v%0d", i), vecs[i].on, vecs[i].ch, vecs[i].voice,
                             vecs[i].note, vecs[i].vel);
            end else begin
                repeat (3) @(posedge clk);
                #1;
                check($sformatf("v%0d.noevt", i), 32'(evt_valid), 32'd0);
            end
            exp_err += vecs[i].err_inc;
            check($sformatf("v%0d.err", i), 32'(err_count), 32'(exp_err));
            check($sformatf("v%0d.busy", i), 32'(busy), 32'd0);
        end

        // Five note-ons into a depth-4 FIFO with the consumer stalled.
        for (int k = 0; k < 5; k++) begin
            send(8'h90);
            send(8'(k));
            send(8'(8'h30 + k));
            send(8'h40);
        end
        repeat (3) @(posedge clk);
        #1;
        exp_err++;
        check("full.level", 32'(fifo_level), 32'd4);
        check("full.err",   32'(err_count), 32'(exp_err));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d.valid", k), 32'(evt_valid), 32'd1);
            check($sformatf("drain%0d.voice", k), 32'(evt_voice), 32'(k));
            check($sformatf("drain%0d.note", k),  32'(evt_note), 32'(8'h30 + k));
            @(posedge clk);
            #1;
            check($sformatf("drain%0d.hold", k),  32'(evt_voice), 32'(k));
            pop_one();
        end
        check("drain.empty", 32'(evt_valid), 32'd0);
        check("drain.level", 32'(fifo_level), 32'd0);

        // Timeout: exactly TMO silent cycles mid-frame returns to idle.
        send(8'h90);
        send(8'h05);
        check("tmo.busy0", 32'(busy), 32'd1);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("tmo.busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        exp_err++;
        check("tmo.busy_after", 32'(busy), 32'd0);
        check("tmo.err",        32'(err_count), 32'(exp_err));

        // Running status.
        send(8'h91);
        send(8'h02);
        send(8'h3C);
        send(8'h64);
        expect_event("rs.first", 1'b1, 4'd1, 4'd2, 7'd60, 7'd100);
        send(8'h04);
        send(8'h3E);
        send(8'h40);
`ifdef MIDI_RUNNING_STATUS_EN
        expect_event("rs.second", 1'b1, 4'd1, 4'd4, 7'd62, 7'd64);
`else
        repeat (3) @(posedge clk);
        #1;
        check("rs.dropped", 32'(evt_valid), 32'd0);
`endif
        check("rs.busy", 32'(busy), 32'd0);
        check("rs.err",  32'(err_count), 32'(exp_err));

        // Reset with an event pending and a frame half received.
        send(8'h90);
        send(8'h01);
        send(8'h3C);
        send(8'h64);
        send(8'h90);
        send(8'h02);
        check("rstmid.pending", 32'(evt_valid), 32'd1);
        check("rstmid.busy0",   32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid.valid", 32'(evt_valid), 32'd0);
        check("rstmid.busy",  32'(busy), 32'd0);
        check("rstmid.level", 32'(fifo_level), 32'd0);
        check("rstmid.err",   32'(err_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 256 mid-frame aborts: the error count must stop at 255.
        send(8'h90);
        for (int k = 0; k < 256; k++) send(8'h90);
        #1;
        check("sat.err", 32'(err_count), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
